pid_ctrl_param: RTL and testbench

Parameterised successor to the fixed-width PID heading controller in the Knight's Tour drive path. It takes a heading error and a forward speed, and computes saturated left and right motor speed commands using P, I and D terms. Term coefficients, the integrator width and the derivative history depth are configurable. It uses a 2-stage pipeline and emits an output-valid strobe that the motor/PWM stage consumes.

---
 rtl/pid_ctrl_param.sv | 147 ++++++++++++++
 tb/tb_pid_ctrl_param.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pid_ctrl_param.sv
// Parameterised PID heading controller: 2-stage pipeline from heading error/forward speed to saturated
// left/right speed commands. Define PID_ANTIWINDUP_EN to freeze the integrator while driving into saturation.
module pid_ctrl_param #(
  parameter int ERR_W   = 12,
  parameter int FRWRD_W = 10,
  parameter int SPD_W   = 11,
  parameter int P_COEF  = 4,
  parameter int D_COEF  = 2,
  parameter int I_W     = 15,
  parameter int I_SHIFT = 4,
  parameter int D_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     moving,
  input  logic                     err_vld,
  input  logic signed [ERR_W-1:0]  error,
  input  logic [FRWRD_W-1:0]       frwrd,
  output logic signed [SPD_W-1:0]  lft_spd,
  output logic signed [SPD_W-1:0]  rght_spd,
  output logic                     out_vld,
  output logic                     sat
);

  localparam int PID_W = 17;
  localparam int SUM_W = ((FRWRD_W + 1 > PID_W) ? FRWRD_W + 1 : PID_W) + 1;
  localparam int IS_W  = I_W + 1;

  localparam logic signed [4:0]       P_C     = 5'(P_COEF);
  localparam logic signed [3:0]       D_C     = 4'(D_COEF);
  localparam logic signed [ERR_W-1:0] ERR_MAX = ERR_W'(511);
  localparam logic signed [ERR_W-1:0] ERR_MIN = ERR_W'(-512);
  localparam logic signed [SUM_W-1:0] SPD_MAX = SUM_W'((2 ** (SPD_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SPD_MIN = SUM_W'(-(2 ** (SPD_W - 1)));

  logic signed [9:0]       err_sat;
  logic signed [9:0]       hist [D_DEPTH];
  logic signed [I_W-1:0]   integ;
  logic signed [I_W:0]     integ_sum;
  logic                    integ_ovf;
  logic                    integ_en;
  logic signed [10:0]      d_diff;
  logic signed [7:0]       d_sat;
  logic signed [15:0]      p_next;
  logic signed [15:0]      s1_p;
  logic signed [11:0]      d_next;
  logic signed [11:0]      s1_d;
  logic [FRWRD_W-1:0]      s1_frwrd;
  logic                    s1_vld;
  logic signed [PID_W-1:0] i_term;
  logic signed [PID_W-1:0] pid;
  logic signed [SUM_W-1:0] lft_sum;
  logic signed [SUM_W-1:0] rght_sum;
  logic signed [SPD_W-1:0] lft_next;
  logic signed [SPD_W-1:0] rght_next;
  logic                    lft_clamp;
  logic                    rght_clamp;
`ifdef PID_ANTIWINDUP_EN
  logic                    sat_dir;
`endif

  // Stage-1 arithmetic: clamp the error, then form P, D and the candidate integrator value.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    err_sat = error[9:0];
    if (error > ERR_MAX)      err_sat = 10'h1FF;
    else if (error < ERR_MIN) err_sat = 10'h200;

    p_next = 16'(err_sat) * 16'(P_C);

    integ_sum = IS_W'(integ) + IS_W'(err_sat);
    integ_ovf = integ_sum[I_W] != integ_sum[I_W-1];

    d_diff = 11'(err_sat) - 11'(hist[D_DEPTH-1]);
    d_sat  = d_diff[7:0];
    if (d_diff > 11'sd127)       d_sat = 8'h7F;
    else if (d_diff < -11'sd128) d_sat = 8'h80;
    d_next = 12'(d_sat) * 12'(D_C);

`ifdef PID_ANTIWINDUP_EN
    // Stop winding further in the direction the output is already pinned.
    integ_en = !integ_ovf && !(sat && (err_sat[9] == sat_dir));
`else
    integ_en = !integ_ovf;
`endif
  end

  // Stage-2 arithmetic: sum the terms, mix with forward speed and clamp each side.
  always_comb begin
    i_term   = PID_W'(integ >>> I_SHIFT);
    pid      = PID_W'(s1_p) + i_term + PID_W'(s1_d);
    lft_sum  = SUM_W'($signed({1'b0, s1_frwrd})) + SUM_W'(pid);
    rght_sum = SUM_W'($signed({1'b0, s1_frwrd})) - SUM_W'(pid);

    lft_clamp  = (lft_sum > SPD_MAX) || (lft_sum < SPD_MIN);
    rght_clamp = (rght_sum > SPD_MAX) || (rght_sum < SPD_MIN);

    lft_next = lft_sum[SPD_W-1:0];
    if (lft_sum > SPD_MAX)      lft_next = SPD_MAX[SPD_W-1:0];
    else if (lft_sum < SPD_MIN) lft_next = SPD_MIN[SPD_W-1:0];

    rght_next = rght_sum[SPD_W-1:0];
    if (rght_sum > SPD_MAX)      rght_next = SPD_MAX[SPD_W-1:0];
    else if (rght_sum < SPD_MIN) rght_next = SPD_MIN[SPD_W-1:0];
  end

  // NOTE: the history shift register is reset along with the rest, because a stale sample would
  // corrupt the first derivative after reset or after the robot stops.
  always_ff @(posedge clk) begin
    if (rst || !moving) begin
      integ    <= '0;
      s1_vld   <= 1'b0;
      s1_p     <= '0;
      s1_d     <= '0;
      s1_frwrd <= '0;
      lft_spd  <= '0;
      rght_spd <= '0;
      out_vld  <= 1'b0;
      sat      <= 1'b0;
`ifdef PID_ANTIWINDUP_EN
      sat_dir  <= 1'b0;
`endif
      for (int i = 0; i < D_DEPTH; i++) hist[i] <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every stage samples pre-edge values.
      s1_vld  <= err_vld;
      out_vld <= s1_vld;
      if (err_vld) begin
        s1_p     <= p_next;
        s1_d     <= d_next;
        s1_frwrd <= frwrd;
        if (integ_en) integ <= integ_sum[I_W-1:0];
        hist[0] <= err_sat;
        for (int i = 1; i < D_DEPTH; i++) hist[i] <= hist[i-1];
      end
      if (s1_vld) begin
        lft_spd  <= lft_next;
        rght_spd <= rght_next;
        sat      <= lft_clamp || rght_clamp;
`ifdef PID_ANTIWINDUP_EN
        sat_dir  <= pid[PID_W-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_pid_ctrl_param.sv
// Directed self-checking bench for pid_ctrl_param; expected speeds are hand-computed from the PID equations.
module tb_pid_ctrl_param;

  logic               clk = 1'b0;
  logic               rst;
  logic               moving;
  logic               err_vld;
  logic signed [11:0] error;
  logic [9:0]         frwrd;
  logic signed [10:0] lft_spd;
  logic signed [10:0] rght_spd;
  logic               out_vld;
  logic               sat;

  int n_tests = 0;
  int n_fail  = 0;

  pid_ctrl_param dut (
    .clk      (clk),
    .rst      (rst),
    .moving   (moving),
    .err_vld  (err_vld),
    .error    (error),
    .frwrd    (frwrd),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .out_vld  (out_vld),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int l, input int r, input int v, input int s);
    check({tag, ".lft"},  int'(lft_spd),  l);
    check({tag, ".rght"}, int'(rght_spd), r);
    check({tag, ".vld"},  int'(out_vld),  v);
    check({tag, ".sat"},  int'(sat),      s);
  endtask

  // Reset with a live sample on the inputs; reset must win.
  task automatic do_reset(input string tag);
    rst = 1'b1; moving = 1'b1; err_vld = 1'b1; error = 12'sd300; frwrd = 10'd50;
    tick();
    tick();
    check_out(tag, 0, 0, 0, 0);
    rst = 1'b0; err_vld = 1'b0;
    tick();
  endtask

  // One accepted sample, spaced 4 cycles; checks the update pulse and that it is one cycle wide.
  task automatic sample(input string tag, input int e, input int f,
                        input int l, input int r, input int s);
    error = 12'(e); frwrd = 10'(f); err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    tick();
    check_out(tag, l, r, 1, s);
    tick();
    check({tag, ".pulse_end"}, int'(out_vld), 0);
    check({tag, ".hold"},      int'(lft_spd), l);
    tick();
  endtask

  initial begin
    rst = 1'b1; moving = 1'b0; err_vld = 1'b0; error = '0; frwrd = '0;

    // Reset then single sample: P=40 I=0 D=20 PID=60.
    do_reset("reset");
    sample("single", 10, 200, 260, 140, 0);

    // Positive saturation: P=2044 I=31 D=254 PID=2329.
    do_reset("reset2");
    sample("sat_pos", 12'h7FF, 200, 1023, -1024, 1);

    // Negative saturation: err_sat=-512, P=-2048 I=-32 D=-256 PID=-2336.
    do_reset("reset3");
    sample("sat_neg", -2048, 0, -1024, 1023, 1);

    // Negative error, arithmetic shift floors: P=-80 I=-2 D=-40 PID=-122.
    do_reset("reset4");
    sample("neg_err", -20, 100, -22, 222, 0);

    // Back-to-back samples of 10: PID 60, 61, 41.
    do_reset("reset5");
    error = 12'sd10; frwrd = 10'd200; err_vld = 1'b1;
    tick();
    tick();
    check_out("b2b1", 260, 140, 1, 0);
    tick();
    check_out("b2b2", 261, 139, 1, 0);
    err_vld = 1'b0;
    tick();
    check_out("b2b3", 241, 159, 1, 0);
    tick();
    check("b2b.pulse_end", int'(out_vld), 0);

    // Moving drop: 5 samples of 10 (5th PID=43), then moving=0 clears everything.
    do_reset("reset6");
    for (int k = 1; k <= 4; k++) begin
      error = 12'sd10; frwrd = 10'd200; err_vld = 1'b1;
      tick();
      err_vld = 1'b0;
      tick(); tick(); tick();
    end
    sample("mv_s5", 10, 200, 243, 157, 0);
    moving = 1'b0; err_vld = 1'b1;
    tick();
    check_out("mv_drop", 0, 0, 0, 0);
    err_vld = 1'b0;
    tick();
    check("mv_drop.vld2", int'(out_vld), 0);
    moving = 1'b1;
    sample("mv_resume", 10, 200, 260, 140, 0);

`ifdef PID_ANTIWINDUP_EN
    // Integrator stays at 511 after the first saturated sample; probe with error=0:
    // I=31, D=-256, PID=-225.
    do_reset("reset7");
    for (int k = 1; k <= 6; k++) sample($sformatf("aw_s%0d", k), 511, 200, 1023, -1024, 1);
    sample("aw_probe", 0, 200, -25, 425, 0);
`else
    // Integrator climbs to 16352 by sample 32 and holds; probe with error=0:
    // I=1022, D=-256, PID=766.
    do_reset("reset7");
    for (int k = 1; k <= 40; k++) begin
      error = 12'sd511; frwrd = 10'd0; err_vld = 1'b1;
      tick();
      err_vld = 1'b0;
      tick(); tick(); tick();
    end
    check("ovf.sat", int'(sat), 1);
    check("ovf.lft", int'(lft_spd), 1023);
    sample("ovf_probe", 0, 0, 766, -766, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
